// File: rtl/rv_fmt_pkg.sv
// Shared RV32I encoding definitions.
//
// Holds the instruction-format codes (also used by the core's immediate-source
// decoder), the RV32I major opcodes, and the signed immediate ranges that each
// format can represent.
package rv_fmt_pkg;

    localparam int unsigned FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_R = 3'b111
    } fmt_e;

    // RV32I major opcodes, instr[6:0]
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Representable signed immediate ranges (inclusive)
    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    // True when imm, read as a signed 32-bit value, lies within [lo, hi].
    function automatic logic imm_fits(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer.
//
// Assembles one 32-bit instruction from its fields and scatters the immediate
// the same way the core's immediate decoder gathers it. err flags an immediate
// that does not fit its format (the word still carries the truncated bits) or
// an illegal format code (word forced to zero).
//
// Ports
//   fmt     in   format code (fmt_e values; others are illegal)
//   opcode  in   instr[6:0]
//   rd      in   instr[11:7]  (I/U/J/R)
//   rs1     in   instr[19:15] (I/S/B/R)
//   rs2     in   instr[24:20] (S/B/R)
//   funct3  in   instr[14:12] (I/S/B/R)
//   funct7  in   instr[31:25] (R)
//   imm     in   signed byte offset / value; U takes imm[31:12]
//   instr   out  encoded word
//   err     out  immediate out of range or format illegal
module imm_pack
    import rv_fmt_pkg::*;
(
    input  logic [FMT_W-1:0] fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic [31:0]      instr,
    output logic             err
);

    always_comb begin
        instr = 32'h0;
        err   = 1'b0;
        case (fmt)
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                err   = !imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err   = !imm_fits(imm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_B: begin
                // imm[0] has no slot: branch targets are halfword aligned
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err   = !imm_fits(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err   = !imm_fits(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                err   = (imm[11:0] != 12'h000);
            end
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            default: begin
                instr = 32'h0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding the instruction-memory write port.
//
// Accepts one field bundle per cycle, encodes it through imm_pack and holds
// the result in a single output register together with the word address it
// is to be written to. Tracks how many words were consumed (saturating) and a
// sticky OR of their error flags.
//
// Ports
//   clk         in   clock, all state on rising edge
//   reset       in   synchronous active-high reset
//   restart     in   reload address to BASE_ADDR, clear count and sticky_err
//   in_valid    in   field bundle valid
//   in_ready    out  bundle accepted when in_valid & in_ready
//   fmt..imm    in   instruction fields (see imm_pack)
//   out_valid   out  encoded word valid
//   out_ready   in   word consumed when out_valid & out_ready
//   out_instr   out  encoded instruction
//   out_addr    out  word address for out_instr
//   out_err     out  error flag for this word
//   sticky_err  out  OR of out_err over consumed words since reset/restart
//   count       out  words consumed since reset/restart, saturates at 2^ADDR_W
module instr_encoder
    import rv_fmt_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FMT_W-1:0]  fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              sticky_err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              sticky_q, sticky_d;

    logic [31:0]       enc_instr;
    logic              enc_err;
    logic              out_fire;

    imm_pack u_imm_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .instr  (enc_instr),
        .err    (enc_err)
    );

    // Output register is free when empty or being drained this cycle.
    assign in_ready = !reset && (!valid_q || out_ready);
    assign out_fire = valid_q && out_ready;

    always_comb begin
        valid_d  = valid_q;
        instr_d  = instr_q;
        err_d    = err_q;
        addr_d   = addr_q;
        count_d  = count_q;
        sticky_d = sticky_q;

        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                instr_d = enc_instr;
                err_d   = enc_err;
            end
        end

        // restart rewinds the bookkeeping only; a pending word stays in the
        // register and is reported at BaseAddr.
        if (restart) begin
            addr_d   = BaseAddr;
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (out_fire) begin
            addr_d   = addr_q + AddrOne;
            if (count_q != CountMax) begin
                count_d = count_q + CountOne;
            end
            sticky_d = sticky_q | err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            err_q    <= 1'b0;
            addr_q   <= BaseAddr;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_instr  = instr_q;
    assign out_err    = err_q;
    assign out_addr   = addr_q;
    assign count      = count_q;
    assign sticky_err = sticky_q;

endmodule
